// File: rtl/game_turn_ctrl_if.sv
// Board RAM port: one shared address/write/read path owned by the turn sequencer.
interface game_turn_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] brd_addr;
    logic              brd_we;
    logic [1:0]        brd_wdata;
    logic [1:0]        brd_rdata;

    modport master (
        output brd_addr,
        output brd_we,
        output brd_wdata,
        input  brd_rdata
    );

    modport slave (
        input  brd_addr,
        input  brd_we,
        input  brd_wdata,
        output brd_rdata
    );
endinterface

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for the triangles-vs-circles board: serial coordinate capture,
// move validation, commit, 4-direction win scan and turn hand-over.
module game_turn_ctrl #(
    parameter int BOARD_N = 10,
    parameter int WIN_LEN = 4,
    parameter int ADDR_W  = 7
) (
    input  logic             clck,
    input  logic             reset,
    input  logic             b0,
    input  logic             b1,
    input  logic             activity,
    input  logic             new_game,
    game_turn_ctrl_if.master brd,
    output logic             turn,
    output logic             busy,
    output logic             err_occupied,
    output logic             err_range,
    output logic             triangle_win,
    output logic             circle_win,
    output logic             draw,
    output logic [6:0]       move_count
);
    localparam int SPAN  = 2 * WIN_LEN - 1;
    localparam int SLOTS = 4 * SPAN;
    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int OFF_W = $clog2(SPAN);
    localparam int SC_W  = $clog2(SLOTS + 1);
    localparam int RUN_W = $clog2(SPAN + 1);
    localparam int CLR_W = $clog2(CELLS + 1);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_RD, S_CHK, S_WR, S_SCAN, S_RESULT, S_OVER
    } state_t;

    state_t             state;
    logic [CLR_W-1:0]   clr_cnt;
    logic [3:0]         bit_cnt;
    logic [3:0]         x_buf;
    logic [3:0]         y_buf;
    logic [1:0]         iss_dir;
    logic [OFF_W-1:0]   iss_off;
    logic [SC_W-1:0]    scan_cnt;
    logic [RUN_W-1:0]   run;
    logic               win_hit;
    // s1: slot whose address is on the bus; s2: slot whose read data is back
    logic               s1_valid, s1_first, s1_self, s1_read;
    logic               s2_valid, s2_first, s2_self, s2_read;

    int                 cx, cy, koff;
    logic               slot_on, slot_self;
    logic [ADDR_W-1:0]  slot_addr, cell_addr;
    logic [RUN_W-1:0]   run_next;
    logic               s2_match;

    // Cell probed by the next scan slot, and the committed cell's own address
    always_comb begin
        koff = int'(iss_off) - (WIN_LEN - 1);
        cx   = int'(x_buf);
        cy   = int'(y_buf);
        case (iss_dir)
            2'd0:    cx = cx + koff;
            2'd1:    cy = cy + koff;
            2'd2:    begin cx = cx + koff; cy = cy + koff; end
            default: begin cx = cx + koff; cy = cy - koff; end
        endcase
        slot_self = (koff == 0);
        slot_on   = (cx >= 0) && (cx < BOARD_N) && (cy >= 0) && (cy < BOARD_N);
        slot_addr = ADDR_W'(cy * BOARD_N + cx);
        cell_addr = ADDR_W'(int'(y_buf) * BOARD_N + int'(x_buf));
    end

    // Run length after folding in the slot whose data is now valid
    always_comb begin
        s2_match = s2_self || (s2_read && (brd.brd_rdata == {1'b1, turn}));
        run_next = '0;
        if (s2_match)
            run_next = (s2_first ? '0 : run) + RUN_W'(1);
    end

    // Main sequencer: owns the RAM port, all outputs registered
    always_ff @(posedge clck) begin
        if (reset || new_game) begin
            state        <= S_CLEAR;
            clr_cnt      <= '0;
            turn         <= 1'b0;
            move_count   <= '0;
            bit_cnt      <= '0;
            busy         <= 1'b1;
            err_occupied <= 1'b0;
            err_range    <= 1'b0;
            triangle_win <= 1'b0;
            circle_win   <= 1'b0;
            draw         <= 1'b0;
            brd.brd_we   <= 1'b0;
            brd.brd_addr <= '0;
            brd.brd_wdata <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            win_hit      <= 1'b0;
            run          <= '0;
            scan_cnt     <= '0;
            iss_dir      <= '0;
            iss_off      <= '0;
            if (reset) begin
                x_buf <= '0;
                y_buf <= '0;
            end
        end else begin
            err_occupied <= 1'b0;
            err_range    <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == CLR_W'(CELLS)) begin
                        brd.brd_we <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        brd.brd_we    <= 1'b1;
                        brd.brd_wdata <= 2'b00;
                        brd.brd_addr  <= ADDR_W'(clr_cnt);
                        clr_cnt       <= clr_cnt + CLR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (activity && bit_cnt == 4'd8) begin
                        if (int'(x_buf) >= BOARD_N || int'(y_buf) >= BOARD_N) begin
                            err_range <= 1'b1;
                            bit_cnt   <= '0;
                        end else begin
                            brd.brd_addr <= cell_addr;
                            brd.brd_we   <= 1'b0;
                            busy         <= 1'b1;
                            state        <= S_RD;
                        end
                    end else if ((b0 ^ b1) && bit_cnt < 4'd8) begin
                        if (bit_cnt < 4'd4)
                            y_buf[bit_cnt[1:0]] <= b1;
                        else
                            x_buf[bit_cnt[1:0]] <= b1;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                S_RD: state <= S_CHK;
                S_CHK: begin
                    if (brd.brd_rdata[1]) begin
                        err_occupied <= 1'b1;
                        bit_cnt      <= '0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        brd.brd_we    <= 1'b1;
                        brd.brd_wdata <= {1'b1, turn};
                        iss_dir       <= '0;
                        iss_off       <= '0;
                        state         <= S_WR;
                    end
                end
                S_WR: begin
                    move_count <= move_count + 7'd1;
                    bit_cnt    <= '0;
                    scan_cnt   <= '0;
                    win_hit    <= 1'b0;
                    run        <= '0;
                    s2_valid   <= 1'b0;
                    state      <= S_SCAN;
                end
                S_SCAN: begin
                    scan_cnt <= scan_cnt + SC_W'(1);
                    if (scan_cnt == SC_W'(SLOTS))
                        state <= S_RESULT;
                    s2_valid <= s1_valid;
                    s2_first <= s1_first;
                    s2_self  <= s1_self;
                    s2_read  <= s1_read;
                    if (s2_valid) begin
                        run <= run_next;
                        if (run_next >= RUN_W'(WIN_LEN))
                            win_hit <= 1'b1;
                    end
                end
                S_RESULT: begin
                    busy <= 1'b0;
                    if (win_hit) begin
                        triangle_win <= ~turn;
                        circle_win   <= turn;
                        state        <= S_OVER;
                    end else if (move_count == 7'(CELLS)) begin
                        draw  <= 1'b1;
                        state <= S_OVER;
                    end else begin
                        turn  <= ~turn;
                        state <= S_IDLE;
                    end
                end
                default: ;
            endcase

            // Slot issue shares WR's exit edge with the first scan slot, so the
            // address stream starts the cycle right after the commit write.
            if (state == S_WR || (state == S_SCAN && scan_cnt < SC_W'(SLOTS - 1))) begin
                brd.brd_we <= 1'b0;
                s1_valid   <= 1'b1;
                s1_first   <= (iss_off == '0);
                s1_self    <= slot_self;
                s1_read    <= slot_on && !slot_self;
                if (slot_on && !slot_self)
                    brd.brd_addr <= slot_addr;
                if (iss_off == OFF_W'(SPAN - 1)) begin
                    iss_off <= '0;
                    iss_dir <= iss_dir + 2'd1;
                end else begin
                    iss_off <= iss_off + OFF_W'(1);
                end
            end else if (state == S_SCAN) begin
                s1_valid <= 1'b0;
            end
        end
    end
endmodule
